// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// instruction classes, ALU operation codes and trap causes.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_ILLEGAL, CLS_OP, CLS_OP_IMM, CLS_LOAD, CLS_STORE,
    CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC
  } instr_class_e;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  typedef enum logic [1:0] {
    CAUSE_NONE        = 2'd0,
    CAUSE_ILLEGAL     = 2'd1,
    CAUSE_MEM_TIMEOUT = 2'd2
  } trap_cause_e;

  // Register-register / register-immediate ALU op; alt selects SUB or SRA.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv_instr_classifier.sv
// Combinational decode of a latched instruction into its class, rd-write flag,
// immediate-operand flag and ALU operation.
module rv_instr_classifier
  import rv_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  output instr_class_e        instr_class,
  output logic                illegal,
  output logic                writes_rd,
  output logic                uses_imm,
  output logic [ALU_OP_W-1:0] alu_op
);

  logic [3:0] alu_code;
  logic       op_f7_ok;
  logic       imm_f7_ok;

  // funct7 only carries SUB/SRA for OP; any other value is not an RV32I encoding.
  assign op_f7_ok = (funct7 == F7_BASE) ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
  // For OP-IMM the funct7 field is immediate bits, except for the shift forms.
  assign imm_f7_ok = (funct3 == 3'b001) ? (funct7 == F7_BASE) :
                     (funct3 == 3'b101) ? (funct7 == F7_BASE || funct7 == F7_ALT) : 1'b1;

  // Opcode classification and ALU operation selection.
  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    instr_class = CLS_ILLEGAL;
    alu_code    = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        if (op_f7_ok) begin
          instr_class = CLS_OP;
          alu_code    = alu_from_funct3(funct3, funct7[5]);
        end
      end
      OPC_OP_IMM: begin
        if (imm_f7_ok) begin
          instr_class = CLS_OP_IMM;
          alu_code    = alu_from_funct3(funct3, funct3 == 3'b101 && funct7[5]);
        end
      end
      OPC_LOAD:   instr_class = CLS_LOAD;
      OPC_STORE:  instr_class = CLS_STORE;
      OPC_BRANCH: begin
        instr_class = CLS_BRANCH;
        alu_code    = ALU_SUB;
      end
      OPC_JAL:    instr_class = CLS_JAL;
      OPC_JALR:   instr_class = CLS_JALR;
      OPC_LUI: begin
        instr_class = CLS_LUI;
        alu_code    = ALU_PASS_B;
      end
      OPC_AUIPC:  instr_class = CLS_AUIPC;
      default:    instr_class = CLS_ILLEGAL;
    endcase
  end

  assign illegal   = (instr_class == CLS_ILLEGAL);
  assign writes_rd = !(instr_class inside {CLS_ILLEGAL, CLS_STORE, CLS_BRANCH});
  assign uses_imm  = !(instr_class inside {CLS_ILLEGAL, CLS_OP, CLS_BRANCH});
  assign alu_op    = ALU_OP_W'(alu_code);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: latches one instruction, walks it through
// FETCH/DECODE/EXEC/MEM/WB, and traps on illegal opcodes or memory timeouts.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT     = 16,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int ALU_OP_W        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                branch_cond,
  input  logic                mem_ready,
  input  logic                trap_ack,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                imm_select,
  output logic                branch_taken,
  output logic                jump,
  output logic                pc_write,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [2:0]          state_dbg
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e              state, state_nxt;
  trap_cause_e         cause_q, cause_nxt;
  logic [6:0]          opcode_q, funct7_q;
  logic [2:0]          funct3_q;
  logic [CNT_W-1:0]    cnt_q;
  instr_class_e        instr_class;
  logic                illegal, writes_rd, uses_imm;
  logic [ALU_OP_W-1:0] cls_alu;
  logic                is_load, is_store, timeout_hit, stage_active;

  rv_instr_classifier #(.ALU_OP_W(ALU_OP_W)) u_classifier (
    .opcode      (opcode_q),
    .funct3      (funct3_q),
    .funct7      (funct7_q),
    .instr_class (instr_class),
    .illegal     (illegal),
    .writes_rd   (writes_rd),
    .uses_imm    (uses_imm),
    .alu_op      (cls_alu)
  );

  assign is_load     = (instr_class == CLS_LOAD);
  assign is_store    = (instr_class == CLS_STORE);
  // The cycle that would bring the wait count to MEM_TIMEOUT without mem_ready.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST) && !mem_ready;

  // State and trap-cause registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      cause_q <= CAUSE_NONE;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
    end
  end

  // Instruction latch, loaded on the FETCH handshake.
  // NOTE: the latch is reset so outputs derived from it are defined straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
    end else if (instr_valid && instr_ready) begin
      opcode_q <= opcode;
      funct3_q <= funct3;
      funct7_q <= funct7;
    end
  end

  // MEM wait counter: cleared in EXEC, counts MEM cycles without mem_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state == S_EXEC) begin
      cnt_q <= '0;
    end else if (state == S_MEM && !mem_ready && MEM_TIMEOUT != 0) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next-state logic and per-state datapath strobes.
  always_comb begin
    state_nxt    = state;
    cause_nxt    = cause_q;
    instr_ready  = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_to_reg   = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    pc_write     = 1'b0;
    trap         = 1'b0;
    case (state)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (!illegal) begin
          state_nxt = S_EXEC;
        end else if (TRAP_ON_ILLEGAL) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end else begin
          pc_write  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC: begin
        case (instr_class)
          CLS_LOAD, CLS_STORE: state_nxt = S_MEM;
          CLS_BRANCH: begin
            branch_taken = branch_cond;
            pc_write     = 1'b1;
            state_nxt    = S_FETCH;
          end
          default: state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        mem_read  = is_load;
        mem_write = is_store;
        if (mem_ready) begin
          if (is_load) begin
            state_nxt = S_WB;
          end else begin
            pc_write  = 1'b1;
            state_nxt = S_FETCH;
          end
        end else if (timeout_hit) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_MEM_TIMEOUT;
        end
      end
      S_WB: begin
        reg_write  = writes_rd;
        mem_to_reg = is_load;
        jump       = (instr_class == CLS_JAL) || (instr_class == CLS_JALR);
        pc_write   = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
        if (trap_ack) begin
          state_nxt = S_FETCH;
          cause_nxt = CAUSE_NONE;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  assign stage_active = (state == S_DECODE) || (state == S_EXEC) ||
                        (state == S_MEM)    || (state == S_WB);
  assign alu_op     = stage_active ? cls_alu : '0;
  assign imm_select = stage_active && uses_imm;
  assign trap_cause = cause_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: a retire scoreboard compares the
// strobes at every pc_write pulse, scenario tasks check timing and traps.
module tb_rv_multicycle_ctrl;
  import rv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid, instr_valid_b;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       branch_cond, mem_ready, trap_ack;

  logic       instr_ready, reg_write, mem_read, mem_write, mem_to_reg, imm_select;
  logic       branch_taken, jump, pc_write, trap;
  logic [3:0] alu_op;
  logic [1:0] trap_cause;
  logic [2:0] state_dbg;

  logic       b_instr_ready, b_reg_write, b_mem_read, b_mem_write, b_mem_to_reg, b_imm_select;
  logic       b_branch_taken, b_jump, b_pc_write, b_trap;
  logic [3:0] b_alu_op;
  logic [1:0] b_trap_cause;
  logic [2:0] b_state_dbg;

  always #5 clk = ~clk;

  rv_multicycle_ctrl #(.MEM_TIMEOUT(16), .TRAP_ON_ILLEGAL(1'b1), .ALU_OP_W(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .branch_cond(branch_cond),
    .mem_ready(mem_ready), .trap_ack(trap_ack), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .imm_select(imm_select),
    .branch_taken(branch_taken), .jump(jump), .pc_write(pc_write), .alu_op(alu_op),
    .trap(trap), .trap_cause(trap_cause), .state_dbg(state_dbg)
  );

  rv_multicycle_ctrl #(.MEM_TIMEOUT(16), .TRAP_ON_ILLEGAL(1'b0), .ALU_OP_W(4)) dut_nop (
    .clk(clk), .rst(rst), .instr_valid(instr_valid_b), .instr_ready(b_instr_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .branch_cond(branch_cond),
    .mem_ready(mem_ready), .trap_ack(trap_ack), .reg_write(b_reg_write), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .mem_to_reg(b_mem_to_reg), .imm_select(b_imm_select),
    .branch_taken(b_branch_taken), .jump(b_jump), .pc_write(b_pc_write), .alu_op(b_alu_op),
    .trap(b_trap), .trap_cause(b_trap_cause), .state_dbg(b_state_dbg)
  );

  typedef struct packed {
    logic       rw;
    logic       m2r;
    logic       jmp;
    logic       bt;
    logic       imm;
    logic [3:0] alu;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_exp, mon_act;
  int   n_checks = 0;
  int   n_fail   = 0;

  int   cyc, pc_cnt, pc_first, rw_cnt, rw_first, mr_cnt, mw_cnt, jmp_cnt, bt_cnt;
  int   mem_seen, mem_wait;
  logic rw_m2r, dec_imm;
  logic [3:0] dec_alu;

  // Retire monitor: every pc_write pulse consumes one expected instruction.
  always @(negedge clk) begin
    if (!rst && pc_write) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL retire_unexpected: pc_write with no pending instruction at %0t", $time);
      end else begin
        mon_exp = sb_q.pop_front();
        mon_act = {reg_write, mem_to_reg, jump, branch_taken, imm_select, alu_op};
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL retire: got rw=%0b m2r=%0b jmp=%0b bt=%0b imm=%0b alu=%0d, expected rw=%0b m2r=%0b jmp=%0b bt=%0b imm=%0b alu=%0d",
                   mon_act.rw, mon_act.m2r, mon_act.jmp, mon_act.bt, mon_act.imm, mon_act.alu,
                   mon_exp.rw, mon_exp.m2r, mon_exp.jmp, mon_exp.bt, mon_exp.imm, mon_exp.alu);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present an instruction (held until it retires or traps) and queue its expected retire.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input bit retires, input exp_t e);
    opcode = op; funct3 = f3; funct7 = f7;
    instr_valid = 1'b1;
    cyc = 1; pc_cnt = 0; pc_first = 0; rw_cnt = 0; rw_first = 0;
    mr_cnt = 0; mw_cnt = 0; jmp_cnt = 0; bt_cnt = 0; mem_seen = 0;
    rw_m2r = 1'b0; dec_imm = 1'b0; dec_alu = '0;
    if (retires) sb_q.push_back(e);
  endtask

  // One clock: drive mem_ready for MEM cycles, then record the strobes.
  task automatic observe();
    @(posedge clk); #1;
    cyc++;
    mem_ready = 1'b0;
    if (state_dbg == S_MEM) begin
      mem_ready = (mem_wait >= 0) && (mem_seen >= mem_wait);
      mem_seen++;
    end
    #1;
    if (pc_write) begin pc_cnt++; if (pc_first == 0) pc_first = cyc; end
    if (reg_write) begin rw_cnt++; if (rw_first == 0) rw_first = cyc; rw_m2r = mem_to_reg; end
    if (mem_read) mr_cnt++;
    if (mem_write) mw_cnt++;
    if (jump) jmp_cnt++;
    if (branch_taken) bt_cnt++;
    if (state_dbg == S_DECODE) begin dec_alu = alu_op; dec_imm = imm_select; end
    if (pc_write || trap) instr_valid = 1'b0;
  endtask

  task automatic run(input int budget);
    do observe(); while (state_dbg != S_FETCH && state_dbg != S_TRAP && cyc < budget);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_valid = 1'b0; instr_valid_b = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
    branch_cond = 1'b0; mem_ready = 1'b0; trap_ack = 1'b0; mem_wait = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (state_dbg !== S_FETCH) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_FETCH); end
    n_checks++;
    if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", instr_ready); end
    n_checks++;
    if ({reg_write, mem_read, mem_write, mem_to_reg, imm_select, branch_taken, jump, pc_write, trap, trap_cause, alu_op} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want all zero",
               {reg_write, mem_read, mem_write, mem_to_reg, imm_select, branch_taken, jump, pc_write, trap, trap_cause, alu_op});
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_add();
    n_checks++;
    if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %0b want 1", instr_ready); end
    issue(7'b0110011, 3'b000, 7'b0000000, 1'b1, '{rw:1, m2r:0, jmp:0, bt:0, imm:0, alu:ALU_ADD});
    run(20);
    n_checks++;
    if (rw_cnt !== 1 || rw_first !== 4) begin n_fail++; $display("FAIL add_reg_write: got count %0d at cycle %0d want 1 at 4", rw_cnt, rw_first); end
    n_checks++;
    if (pc_cnt !== 1) begin n_fail++; $display("FAIL add_pc_write: got %0d pulses want 1", pc_cnt); end
    n_checks++;
    if (cyc - 1 !== 4) begin n_fail++; $display("FAIL add_latency: got %0d want 4", cyc - 1); end
    n_checks++;
    if (dec_alu !== ALU_ADD || dec_imm !== 1'b0) begin n_fail++; $display("FAIL add_decode: got alu=%0d imm=%0b want alu=%0d imm=0", dec_alu, dec_imm, ALU_ADD); end
  endtask

  task automatic test_load();
    mem_wait = 3;
    issue(7'b0000011, 3'b010, 7'b0000000, 1'b1, '{rw:1, m2r:1, jmp:0, bt:0, imm:1, alu:ALU_ADD});
    run(30);
    n_checks++;
    if (mr_cnt !== 4) begin n_fail++; $display("FAIL lw_mem_read: got %0d cycles want 4", mr_cnt); end
    n_checks++;
    if (rw_cnt !== 1 || rw_m2r !== 1'b1) begin n_fail++; $display("FAIL lw_writeback: got rw=%0d m2r=%0b want rw=1 m2r=1", rw_cnt, rw_m2r); end
    n_checks++;
    if (cyc - 1 !== 8) begin n_fail++; $display("FAIL lw_wait_latency: got %0d want 8", cyc - 1); end
    mem_wait = 0;
    issue(7'b0000011, 3'b010, 7'b0000000, 1'b1, '{rw:1, m2r:1, jmp:0, bt:0, imm:1, alu:ALU_ADD});
    run(30);
    n_checks++;
    if (cyc - 1 !== 5 || mr_cnt !== 1) begin n_fail++; $display("FAIL lw_zero_wait: got latency %0d mem_read %0d want 5 and 1", cyc - 1, mr_cnt); end
  endtask

  task automatic test_branch();
    for (int c = 1; c >= 0; c--) begin
      branch_cond = c[0];
      issue(7'b1100011, 3'b000, 7'b0000000, 1'b1, '{rw:0, m2r:0, jmp:0, bt:c[0], imm:0, alu:ALU_SUB});
      run(20);
      n_checks++;
      if (bt_cnt !== c) begin n_fail++; $display("FAIL beq_taken: cond=%0d got %0d pulses want %0d", c, bt_cnt, c); end
      n_checks++;
      if (rw_cnt !== 0 || pc_first !== 3 || cyc - 1 !== 3) begin
        n_fail++;
        $display("FAIL beq_timing: cond=%0d got rw=%0d pc_cycle=%0d latency=%0d want 0 3 3", c, rw_cnt, pc_first, cyc - 1);
      end
    end
    branch_cond = 1'b0;
  endtask

  task automatic test_jalr();
    issue(7'b1100111, 3'b000, 7'b0000000, 1'b1, '{rw:1, m2r:0, jmp:1, bt:0, imm:1, alu:ALU_ADD});
    run(20);
    n_checks++;
    if (jmp_cnt !== 1 || rw_cnt !== 1 || dec_imm !== 1'b1) begin
      n_fail++;
      $display("FAIL jalr: got jump=%0d rw=%0d imm=%0b want 1 1 1", jmp_cnt, rw_cnt, dec_imm);
    end
  endtask

  task automatic test_alu_table();
    logic [6:0] t_op [11] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0010011,
                              7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0100011};
    logic [2:0] t_f3 [11] = '{3'b000, 3'b101, 3'b011, 3'b000, 3'b101, 3'b101, 3'b110, 3'b000, 3'b000, 3'b000, 3'b010};
    logic [6:0] t_f7 [11] = '{7'h20, 7'h20, 7'h00, 7'h20, 7'h20, 7'h00, 7'h55, 7'h00, 7'h00, 7'h00, 7'h00};
    exp_t       t_e  [11] = '{'{1, 0, 0, 0, 0, ALU_SUB},  '{1, 0, 0, 0, 0, ALU_SRA},
                              '{1, 0, 0, 0, 0, ALU_SLTU}, '{1, 0, 0, 0, 1, ALU_ADD},
                              '{1, 0, 0, 0, 1, ALU_SRA},  '{1, 0, 0, 0, 1, ALU_SRL},
                              '{1, 0, 0, 0, 1, ALU_OR},   '{1, 0, 0, 0, 1, ALU_PASS_B},
                              '{1, 0, 0, 0, 1, ALU_ADD},  '{1, 0, 1, 0, 1, ALU_ADD},
                              '{0, 0, 0, 0, 1, ALU_ADD}};
    mem_wait = 0;
    for (int i = 0; i < 11; i++) begin
      issue(t_op[i], t_f3[i], t_f7[i], 1'b1, t_e[i]);
      run(20);
    end
  endtask

  task automatic test_illegal_trap();
    issue(7'b1111111, 3'b000, 7'b0000000, 1'b0, '0);
    run(10);
    n_checks++;
    if (trap !== 1'b1 || trap_cause !== 2'd1 || pc_cnt !== 0) begin
      n_fail++;
      $display("FAIL illegal_trap: got trap=%0b cause=%0d pc=%0d want 1 1 0", trap, trap_cause, pc_cnt);
    end
    repeat (3) observe();
    n_checks++;
    if (trap !== 1'b1 || trap_cause !== 2'd1 || instr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_hold: got trap=%0b cause=%0d ready=%0b want 1 1 0", trap, trap_cause, instr_ready);
    end
    trap_ack = 1'b1;
    observe();
    n_checks++;
    if (instr_ready !== 1'b1 || trap !== 1'b0 || trap_cause !== 2'd0) begin
      n_fail++;
      $display("FAIL illegal_ack: got ready=%0b trap=%0b cause=%0d want 1 0 0", instr_ready, trap, trap_cause);
    end
    observe();
    n_checks++;
    if (state_dbg !== S_FETCH) begin n_fail++; $display("FAIL ack_outside_trap: got state %0d want %0d", state_dbg, S_FETCH); end
    trap_ack = 1'b0;
  endtask

  task automatic test_illegal_nop();
    int b_pc = 0;
    int b_tr = 0;
    logic [2:0] b_st3 = '1;
    opcode = 7'b1111111; funct3 = '0; funct7 = '0;
    instr_valid_b = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      @(posedge clk); #2;
      if (b_pc_write) begin b_pc++; instr_valid_b = 1'b0; end
      if (b_trap) b_tr++;
      if (i == 3) b_st3 = b_state_dbg;
    end
    instr_valid_b = 1'b0;
    n_checks++;
    if (b_pc !== 1 || b_tr !== 0) begin n_fail++; $display("FAIL illegal_nop: got pc=%0d trap=%0d want 1 0", b_pc, b_tr); end
    n_checks++;
    if (b_st3 !== S_FETCH) begin n_fail++; $display("FAIL illegal_nop_return: got state %0d want %0d", b_st3, S_FETCH); end
  endtask

  task automatic test_mem_timeout();
    mem_wait = 15;
    issue(7'b0100011, 3'b010, 7'b0000000, 1'b1, '{rw:0, m2r:0, jmp:0, bt:0, imm:1, alu:ALU_ADD});
    run(40);
    n_checks++;
    if (mw_cnt !== 16 || pc_cnt !== 1 || state_dbg !== S_FETCH) begin
      n_fail++;
      $display("FAIL sw_ready_at_limit: got mem_write=%0d pc=%0d state=%0d want 16 1 %0d", mw_cnt, pc_cnt, state_dbg, S_FETCH);
    end
    mem_wait = -1;
    issue(7'b0100011, 3'b010, 7'b0000000, 1'b0, '0);
    run(40);
    n_checks++;
    if (mw_cnt !== 16 || trap !== 1'b1 || trap_cause !== 2'd2) begin
      n_fail++;
      $display("FAIL sw_timeout: got mem_write=%0d trap=%0b cause=%0d want 16 1 2", mw_cnt, trap, trap_cause);
    end
    n_checks++;
    if (mem_write !== 1'b0 || pc_cnt !== 0) begin n_fail++; $display("FAIL sw_timeout_strobes: got mem_write=%0b pc=%0d want 0 0", mem_write, pc_cnt); end
    trap_ack = 1'b1;
    observe();
    trap_ack = 1'b0;
    issue(7'b0100011, 3'b010, 7'b0000000, 1'b0, '0);
    do observe(); while (state_dbg != S_MEM && cyc < 10);
    observe();
    n_checks++;
    if (mem_write !== 1'b1) begin n_fail++; $display("FAIL sw_pre_reset: got mem_write=%0b want 1", mem_write); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_write !== 1'b0 || state_dbg !== S_FETCH) begin
      n_fail++;
      $display("FAIL async_reset: got mem_write=%0b state=%0d want 0 %0d", mem_write, state_dbg, S_FETCH);
    end
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_branch();
    test_jalr();
    test_alu_table();
    test_illegal_trap();
    test_illegal_nop();
    test_mem_timeout();
    repeat (2) @(posedge clk);
    n_checks++;
    if (sb_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
